mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares one synchronous-read memory port between the core's instruction-fetch requester and its load/store requester. This lets the RV32I core run from a single unified BRAM instead of separate combinational instruction and data memories. One transaction is outstanding at a time; the core stalls its fetch or MEM stage until it receives a grant or read response. The block sits between the IF/MEM stage logic and the memory macro.

Parameters:
ADDR_W, 32, byte-address width passed to memory unchanged.
MEM_LAT, 1, memory read latency in cycles from mem_en to valid mem_rdata. Legal range 1..4; any other value is an elaboration error.
D_PRIORITY, 1, arbitration mode. 1 = data port has fixed priority over fetch. 0 = round-robin.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
if_req  in  1  fetch request; held with if_addr stable until if_gnt
if_addr  in  ADDR_W  fetch byte address
if_gnt  out  1  fetch request accepted this cycle
if_rvalid  out  1  one-cycle pulse; if_rdata valid
if_rdata  out  32  fetched word
d_req  in  1  data request; held with d_* stable until d_gnt
d_we  in  1  1 = store, 0 = load
d_addr  in  ADDR_W  data byte address
d_wdata  in  32  store data, already lane-aligned
d_wstrb  in  4  store byte enables
d_gnt  out  1  data request accepted this cycle
d_rvalid  out  1  one-cycle pulse; d_rdata valid (loads only)
d_rdata  out  32  loaded word
mem_en  out  1  memory access strobe
mem_we  out  4  memory byte write enables
mem_addr  out  ADDR_W  memory address
mem_wdata  out  32  memory write data
mem_rdata  in  32  memory read data, valid MEM_LAT cycles after mem_en
busy  out  1  read in flight (state != IDLE)

Behaviour:
- States:
  - IDLE: grants are possible.
  - WAIT: a read is in flight. A counter runs MEM_LAT cycles.
- Grant logic:
  - Grants are combinational from the req inputs, and are issued only in IDLE.
  - At most one grant per cycle.
  - D_PRIORITY=1: if d_req is high, d_gnt wins; otherwise if_req gets if_gnt.
  - D_PRIORITY=0, both requesting: grant the port not granted last. A last_owner register updates on every grant.
  - D_PRIORITY=0, one requesting: grant it.
- Memory side in the grant cycle:
  - mem_en=1.
  - mem_addr = granted address.
  - mem_we = d_wstrb for a data store, else 4'b0000.
  - mem_wdata = d_wdata.
  - With no grant, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Store grant:
  - The store completes at the clock edge and the FSM stays in IDLE.
  - No d_rvalid is produced. d_gnt is the completion acknowledge.
  - Back-to-back stores are possible every cycle.
- Read grant (fetch, or load with d_we=0):
  - The FSM goes to WAIT with the owner recorded.
  - After MEM_LAT WAIT cycles, mem_rdata is sampled at the end of the last WAIT cycle into the owner's rdata register. The FSM then returns to IDLE.
  - The owner's rvalid is high for exactly the first IDLE cycle after WAIT.
  - A new grant may be issued in that same cycle.
  - Response latency is MEM_LAT+1 cycles after the grant cycle; read throughput is one per MEM_LAT+1 cycles.
- WAIT cycles:
  - Requests are ignored; if_gnt=d_gnt=0 and mem_en=0.
  - busy=1.
- Handshake rules:
  - A requester may drop req before its grant with no side effect.
  - A requester must not change addr/data while req is high and ungranted.
  - rdata registers hold their value until overwritten by the next read for the same port.
- Starvation: with D_PRIORITY=1, fetch may starve while d_req stays high. This is accepted; the core issues at most one data access per instruction.
- Reset values:
  - state=IDLE, counter=0, last_owner=fetch (the first round-robin tie goes to data).
  - if_rvalid=d_rvalid=0, if_rdata=d_rdata=0, busy=0.
- Reset mid-WAIT:
  - The transaction is abandoned and no rvalid pulses.
  - After deassertion, a grant is available in the first cycle.
- Addresses are not checked for alignment; misaligned handling belongs to the MEM stage.

Test Plan:
1. MEM_LAT=1, memory model returns addr^32'h5A5A0000; if_req with if_addr=0x100 at cycle T -> if_gnt=1, mem_en=1, mem_addr=0x100 at T; if_rvalid=1 with if_rdata=0x5A5A0100 at T+2 only; busy=1 at T+1.
2. D_PRIORITY=1, at T d_req load 0x2000 and if_req 0x4 -> d_gnt at T, d_rvalid at T+2 (data 0x5A5A2000); if_gnt at T+2, if_rvalid at T+4.
3. Store d_we=1, d_addr=0x10, d_wdata=0xAABBCCDD, d_wstrb=4'b0011 at T -> d_gnt at T, mem_we=4'b0011, mem_wdata=0xAABBCCDD; no d_rvalid; a pending if_req is granted at T+1.
4. D_PRIORITY=0, both ports issuing reads continuously after reset -> grant order D, I, D, I, with grants every 2 cycles (MEM_LAT=1).
5. MEM_LAT=3, fetch read at T -> busy=1 at T+1..T+3; d_req raised at T+1 gets no grant until T+4; if_rvalid at T+4 in the same cycle as d_gnt.
6. rst pulse during WAIT (MEM_LAT=3) -> no rvalid pulse ever for that read; all outputs 0; an if_req held through reset is granted in the first cycle after deassertion.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one synchronous-read memory port between fetch and load/store
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter bit D_PRIORITY = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [3:0]        d_wstrb,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              busy
);

  generate
    if (MEM_LAT < 1 || MEM_LAT > 4) begin : g_bad_mem_lat
      $error("mem_port_arbiter: MEM_LAT must be in 1..4");
    end
  endgenerate

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;
  localparam logic [1:0] LAT_LAST = 2'(MEM_LAT - 1);

  logic [0:0] state;
  logic [1:0] cnt;
  logic       owner_d;
  logic       last_d;
  logic       can_grant;
  logic       pick_d;
  logic       start_read;

  // Grants are suppressed while reset is held so every output reads zero in reset.
  assign can_grant = (state == S_IDLE) && !rst;

  always_comb begin
    pick_d = 1'b0;
    if (D_PRIORITY)
      pick_d = d_req;
    else if (d_req && if_req)
      pick_d = !last_d;
    else
      pick_d = d_req;
  end

  assign d_gnt      = can_grant && d_req && pick_d;
  assign if_gnt     = can_grant && if_req && !pick_d;
  assign mem_en     = d_gnt || if_gnt;
  assign mem_addr   = d_gnt ? d_addr : (if_gnt ? if_addr : '0);
  assign mem_we     = (d_gnt && d_we) ? d_wstrb : 4'b0000;
  assign mem_wdata  = mem_en ? d_wdata : 32'h0;
  assign start_read = if_gnt || (d_gnt && !d_we);
  assign busy       = (state == S_WAIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= 2'd0;
      owner_d   <= 1'b0;
      last_d    <= 1'b0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      if_rdata  <= 32'h0;
      d_rdata   <= 32'h0;
    end else begin
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      if (mem_en)
        last_d <= d_gnt;
      case (state)
        S_IDLE: begin
          if (start_read) begin
            state   <= S_WAIT;
            cnt     <= 2'd0;
            owner_d <= d_gnt;
          end
        end
        S_WAIT: begin
          // Memory data is valid during the last WAIT cycle; capture it at its closing edge.
          if (cnt == LAT_LAST) begin
            state <= S_IDLE;
            cnt   <= 2'd0;
            if (owner_d) begin
              d_rvalid <= 1'b1;
              d_rdata  <= mem_rdata;
            end else begin
              if_rvalid <= 1'b1;
              if_rdata  <= mem_rdata;
            end
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - bench for mem_port_arbiter over three latency/priority configurations
module tb_mem_port_arbiter;

  localparam logic [31:0] K = 32'h5A5A0000;

  logic        clk;
  logic        rst;
  logic        if_req    [3];
  logic [31:0] if_addr   [3];
  logic        if_gnt    [3];
  logic        if_rvalid [3];
  logic [31:0] if_rdata  [3];
  logic        d_req     [3];
  logic        d_we      [3];
  logic [31:0] d_addr    [3];
  logic [31:0] d_wdata   [3];
  logic [3:0]  d_wstrb   [3];
  logic        d_gnt     [3];
  logic        d_rvalid  [3];
  logic [31:0] d_rdata   [3];
  logic        mem_en    [3];
  logic [3:0]  mem_we    [3];
  logic [31:0] mem_addr  [3];
  logic [31:0] mem_wdata [3];
  logic [31:0] mem_rdata [3];
  logic        busy      [3];

  int n_checks = 0;
  int n_fail   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instance 0: MEM_LAT=1 data priority; 1: MEM_LAT=1 round-robin; 2: MEM_LAT=3 data priority.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = (g == 2) ? 3 : 1;
    localparam bit P = (g == 1) ? 1'b0 : 1'b1;
    logic [31:0] sr [4];
    always @(posedge clk) begin
      sr[0] <= mem_en[g] ? (mem_addr[g] ^ K) : 32'hBADBAD00;
      for (int k = 1; k < 4; k++) sr[k] <= sr[k-1];
    end
    assign mem_rdata[g] = sr[L-1];

    mem_port_arbiter #(.ADDR_W(32), .MEM_LAT(L), .D_PRIORITY(P)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req[g]), .if_addr(if_addr[g]), .if_gnt(if_gnt[g]),
      .if_rvalid(if_rvalid[g]), .if_rdata(if_rdata[g]),
      .d_req(d_req[g]), .d_we(d_we[g]), .d_addr(d_addr[g]), .d_wdata(d_wdata[g]),
      .d_wstrb(d_wstrb[g]), .d_gnt(d_gnt[g]), .d_rvalid(d_rvalid[g]), .d_rdata(d_rdata[g]),
      .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
      .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g]), .busy(busy[g])
    );
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic ir, input logic [31:0] ia, input logic dr,
                       input logic dwe, input logic [31:0] da, input logic [31:0] dwd,
                       input logic [3:0] ds);
    if_req[i]  = ir;
    if_addr[i] = ia;
    d_req[i]   = dr;
    d_we[i]    = dwe;
    d_addr[i]  = da;
    d_wdata[i] = dwd;
    d_wstrb[i] = ds;
  endtask

  // Leaves the bench #1 after the edge of the first cycle with reset released.
  task automatic do_reset();
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) drive(i, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) drive(i, 1, 32'h20, 1, 0, 32'h30, 32'h1234, 4'hF);
    tick();
    tick();
    #2;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (if_gnt[i] !== 0 || d_gnt[i] !== 0 || mem_en[i] !== 0 || mem_we[i] !== 0 ||
          mem_addr[i] !== 0 || mem_wdata[i] !== 0 || busy[i] !== 0 || if_rvalid[i] !== 0 ||
          d_rvalid[i] !== 0 || if_rdata[i] !== 0 || d_rdata[i] !== 0) begin
        n_fail++;
        $display("FAIL reset_outputs[%0d]: gnt=%b%b en=%b we=%h addr=%h wd=%h busy=%b rv=%b%b rd=%h/%h, required all zero",
                 i, if_gnt[i], d_gnt[i], mem_en[i], mem_we[i], mem_addr[i], mem_wdata[i],
                 busy[i], if_rvalid[i], d_rvalid[i], if_rdata[i], d_rdata[i]);
      end
    end
    tick();
    rst = 1'b0;
    #2;
    n_checks++;
    if (d_gnt[0] !== 1'b1 || if_gnt[0] !== 1'b0 || mem_addr[0] !== 32'h30) begin
      n_fail++;
      $display("FAIL reset_release_grant: d_gnt=%b if_gnt=%b addr=%h, required 1 0 00000030",
               d_gnt[0], if_gnt[0], mem_addr[0]);
    end
    for (int i = 0; i < 3; i++) drive(i, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_fetch_read();
    do_reset();
    drive(0, 1, 32'h100, 0, 0, 0, 0, 0);
    #2;
    n_checks++;
    if (if_gnt[0] !== 1 || mem_en[0] !== 1 || mem_addr[0] !== 32'h100 || mem_we[0] !== 0 || if_rvalid[0] !== 0) begin
      n_fail++;
      $display("FAIL fetch_grant: gnt=%b en=%b addr=%h we=%h rv=%b, required 1 1 00000100 0 0",
               if_gnt[0], mem_en[0], mem_addr[0], mem_we[0], if_rvalid[0]);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    n_checks++;
    if (busy[0] !== 1 || if_rvalid[0] !== 0 || mem_en[0] !== 0) begin
      n_fail++;
      $display("FAIL fetch_wait: busy=%b rv=%b en=%b, required 1 0 0", busy[0], if_rvalid[0], mem_en[0]);
    end
    tick();
    #2;
    n_checks++;
    if (if_rvalid[0] !== 1 || if_rdata[0] !== 32'h5A5A0100 || busy[0] !== 0) begin
      n_fail++;
      $display("FAIL fetch_response: rv=%b data=%h busy=%b, required 1 5a5a0100 0", if_rvalid[0], if_rdata[0], busy[0]);
    end
    tick();
    #2;
    n_checks++;
    if (if_rvalid[0] !== 0 || if_rdata[0] !== 32'h5A5A0100) begin
      n_fail++;
      $display("FAIL fetch_pulse_hold: rv=%b data=%h, required 0 5a5a0100", if_rvalid[0], if_rdata[0]);
    end
  endtask

  task automatic test_d_priority();
    do_reset();
    drive(0, 1, 32'h4, 1, 0, 32'h2000, 0, 0);
    #2;
    n_checks++;
    if (d_gnt[0] !== 1 || if_gnt[0] !== 0 || mem_addr[0] !== 32'h2000) begin
      n_fail++;
      $display("FAIL prio_grant: d_gnt=%b if_gnt=%b addr=%h, required 1 0 00002000", d_gnt[0], if_gnt[0], mem_addr[0]);
    end
    tick();
    drive(0, 1, 32'h4, 0, 0, 0, 0, 0);
    #2;
    n_checks++;
    if (if_gnt[0] !== 0 || busy[0] !== 1) begin
      n_fail++;
      $display("FAIL prio_wait: if_gnt=%b busy=%b, required 0 1", if_gnt[0], busy[0]);
    end
    tick();
    #2;
    n_checks++;
    if (d_rvalid[0] !== 1 || d_rdata[0] !== 32'h5A5A2000 || if_gnt[0] !== 1 || mem_addr[0] !== 32'h4) begin
      n_fail++;
      $display("FAIL prio_load_resp: d_rv=%b d_rdata=%h if_gnt=%b addr=%h, required 1 5a5a2000 1 00000004",
               d_rvalid[0], d_rdata[0], if_gnt[0], mem_addr[0]);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    #2;
    n_checks++;
    if (if_rvalid[0] !== 1 || if_rdata[0] !== 32'h5A5A0004 || d_rvalid[0] !== 0 || d_rdata[0] !== 32'h5A5A2000) begin
      n_fail++;
      $display("FAIL prio_fetch_resp: if_rv=%b if_rdata=%h d_rv=%b d_rdata=%h, required 1 5a5a0004 0 5a5a2000",
               if_rvalid[0], if_rdata[0], d_rvalid[0], d_rdata[0]);
    end
  endtask

  task automatic test_store();
    do_reset();
    drive(0, 1, 32'h8, 1, 1, 32'h10, 32'hAABBCCDD, 4'b0011);
    #2;
    n_checks++;
    if (d_gnt[0] !== 1 || if_gnt[0] !== 0 || mem_we[0] !== 4'b0011 || mem_wdata[0] !== 32'hAABBCCDD || mem_addr[0] !== 32'h10) begin
      n_fail++;
      $display("FAIL store_grant: d_gnt=%b if_gnt=%b we=%b wd=%h addr=%h, required 1 0 0011 aabbccdd 00000010",
               d_gnt[0], if_gnt[0], mem_we[0], mem_wdata[0], mem_addr[0]);
    end
    tick();
    drive(0, 1, 32'h8, 0, 0, 0, 0, 0);
    #2;
    n_checks++;
    if (if_gnt[0] !== 1 || d_rvalid[0] !== 0 || mem_we[0] !== 0 || mem_addr[0] !== 32'h8) begin
      n_fail++;
      $display("FAIL store_then_fetch: if_gnt=%b d_rv=%b we=%b addr=%h, required 1 0 0000 00000008",
               if_gnt[0], d_rvalid[0], mem_we[0], mem_addr[0]);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    for (int k = 0; k < 3; k++) begin
      if (k > 0) tick();
      drive(0, 0, 0, 1, 1, 32'h40 + 4 * k, 32'h11110000 + k, 4'hF);
      #2;
      n_checks++;
      if (d_gnt[0] !== 1 || mem_we[0] !== 4'hF || d_rvalid[0] !== 0 || busy[0] !== 0) begin
        n_fail++;
        $display("FAIL back_to_back_store[%0d]: d_gnt=%b we=%h d_rv=%b busy=%b, required 1 f 0 0",
                 k, d_gnt[0], mem_we[0], d_rvalid[0], busy[0]);
      end
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_round_robin();
    do_reset();
    drive(1, 1, 32'h1000, 1, 0, 32'h3000, 0, 0);
    for (int c = 0; c < 8; c++) begin
      if (c > 0) tick();
      #2;
      n_checks++;
      if (d_gnt[1] !== (c % 4 == 0) || if_gnt[1] !== (c % 4 == 2)) begin
        n_fail++;
        $display("FAIL round_robin_c%0d: d_gnt=%b if_gnt=%b, required %b %b",
                 c, d_gnt[1], if_gnt[1], (c % 4 == 0), (c % 4 == 2));
      end
    end
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_long_latency();
    do_reset();
    drive(2, 1, 32'h40, 0, 0, 0, 0, 0);
    #2;
    n_checks++;
    if (if_gnt[2] !== 1) begin
      n_fail++;
      $display("FAIL lat3_grant: if_gnt=%b, required 1", if_gnt[2]);
    end
    for (int c = 1; c <= 3; c++) begin
      tick();
      drive(2, 0, 0, 1, 0, 32'h80, 0, 0);
      #2;
      n_checks++;
      if (busy[2] !== 1 || d_gnt[2] !== 0 || if_rvalid[2] !== 0) begin
        n_fail++;
        $display("FAIL lat3_wait_t%0d: busy=%b d_gnt=%b rv=%b, required 1 0 0", c, busy[2], d_gnt[2], if_rvalid[2]);
      end
    end
    tick();
    #2;
    n_checks++;
    if (if_rvalid[2] !== 1 || if_rdata[2] !== 32'h5A5A0040 || d_gnt[2] !== 1 || busy[2] !== 0) begin
      n_fail++;
      $display("FAIL lat3_resp: rv=%b data=%h d_gnt=%b busy=%b, required 1 5a5a0040 1 0",
               if_rvalid[2], if_rdata[2], d_gnt[2], busy[2]);
    end
    tick();
    drive(2, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    tick();
    #2;
    n_checks++;
    if (d_rvalid[2] !== 1 || d_rdata[2] !== 32'h5A5A0080) begin
      n_fail++;
      $display("FAIL lat3_load_resp: d_rv=%b d_rdata=%h, required 1 5a5a0080", d_rvalid[2], d_rdata[2]);
    end
  endtask

  task automatic test_reset_mid_wait();
    int rv_seen;
    do_reset();
    drive(2, 1, 32'h44, 0, 0, 0, 0, 0);
    tick();
    drive(2, 0, 0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b1;
    drive(2, 1, 32'h48, 0, 0, 0, 0, 0);
    rv_seen = 0;
    for (int c = 0; c < 3; c++) begin
      #2;
      n_checks++;
      if (if_gnt[2] !== 0 || mem_en[2] !== 0 || busy[2] !== 0 || if_rvalid[2] !== 0 || if_rdata[2] !== 0) begin
        n_fail++;
        $display("FAIL midwait_in_reset_c%0d: gnt=%b en=%b busy=%b rv=%b data=%h, required all zero",
                 c, if_gnt[2], mem_en[2], busy[2], if_rvalid[2], if_rdata[2]);
      end
      tick();
    end
    rst = 1'b0;
    #2;
    n_checks++;
    if (if_gnt[2] !== 1 || mem_addr[2] !== 32'h48 || if_rvalid[2] !== 0) begin
      n_fail++;
      $display("FAIL midwait_first_grant: gnt=%b addr=%h rv=%b, required 1 00000048 0", if_gnt[2], mem_addr[2], if_rvalid[2]);
    end
    for (int c = 1; c <= 3; c++) begin
      tick();
      drive(2, 0, 0, 0, 0, 0, 0, 0);
      #2;
      if (if_rvalid[2] !== 0) rv_seen++;
    end
    n_checks++;
    if (rv_seen != 0) begin
      n_fail++;
      $display("FAIL midwait_stray_rvalid: pulses=%0d, required 0", rv_seen);
    end
    tick();
    #2;
    n_checks++;
    if (if_rvalid[2] !== 1 || if_rdata[2] !== 32'h5A5A0048) begin
      n_fail++;
      $display("FAIL midwait_after_reset_resp: rv=%b data=%h, required 1 5a5a0048", if_rvalid[2], if_rdata[2]);
    end
  endtask

  // Random traffic against a timeline model: the port is free again LAT+1 cycles after a read grant,
  // and the owner's response lands exactly then with addr^K.
  task automatic test_random(input int i, input int ncyc);
    int          lat, cyc, free_at, if_at, d_at, shown;
    bit          prio_d, last_d, idle, gi, gd;
    logic        ir, dr, dwe;
    logic [31:0] ia, da, dwd, if_pend, d_pend, if_hold, d_hold;
    logic [3:0]  ds;
    logic [3:0]  e_we;
    logic [31:0] e_addr, e_wd;
    lat    = (i == 2) ? 3 : 1;
    prio_d = (i != 1);
    last_d = 0;
    free_at = 0; if_at = -1; d_at = -1; shown = 0;
    if_hold = 0; d_hold = 0; if_pend = 0; d_pend = 0;
    ir = 0; dr = 0; dwe = 0; ia = 0; da = 0; dwd = 0; ds = 0;
    do_reset();
    for (cyc = 0; cyc < ncyc; cyc++) begin
      if (cyc > 0) tick();
      if (!ir && $urandom_range(2, 0) == 0) begin
        ir = 1; ia = $urandom;
      end else if (ir && $urandom_range(15, 0) == 0) begin
        ir = 0;
      end
      if (!dr && $urandom_range(2, 0) == 0) begin
        dr = 1; dwe = $urandom_range(1, 0); da = $urandom; dwd = $urandom; ds = 4'($urandom_range(15, 0));
      end else if (dr && $urandom_range(15, 0) == 0) begin
        dr = 0;
      end
      drive(i, ir, ia, dr, dwe, da, dwd, ds);
      #2;
      if (cyc == if_at) if_hold = if_pend;
      if (cyc == d_at)  d_hold  = d_pend;
      idle = (cyc >= free_at);
      gi = 0; gd = 0;
      if (idle) begin
        if (ir && dr) begin
          if (prio_d || !last_d) gd = 1; else gi = 1;
        end else begin
          gd = dr; gi = ir;
        end
      end
      e_we   = (gd && dwe) ? ds : 4'b0;
      e_addr = gd ? da : (gi ? ia : 32'h0);
      e_wd   = (gd || gi) ? dwd : 32'h0;
      n_checks++;
      if (if_gnt[i] !== gi || d_gnt[i] !== gd || mem_en[i] !== (gi || gd) || mem_we[i] !== e_we ||
          mem_addr[i] !== e_addr || mem_wdata[i] !== e_wd || busy[i] !== !idle) begin
        n_fail++;
        if (shown++ < 10)
          $display("FAIL random%0d_req_side c%0d: gnt i/d=%b%b en=%b we=%h addr=%h wd=%h busy=%b, required %b%b %b %h %h %h %b",
                   i, cyc, if_gnt[i], d_gnt[i], mem_en[i], mem_we[i], mem_addr[i], mem_wdata[i], busy[i],
                   gi, gd, gi || gd, e_we, e_addr, e_wd, !idle);
      end
      n_checks++;
      if (if_rvalid[i] !== (cyc == if_at) || d_rvalid[i] !== (cyc == d_at) ||
          if_rdata[i] !== if_hold || d_rdata[i] !== d_hold) begin
        n_fail++;
        if (shown++ < 10)
          $display("FAIL random%0d_resp_side c%0d: rv i/d=%b%b rdata=%h/%h, required %b%b %h/%h",
                   i, cyc, if_rvalid[i], d_rvalid[i], if_rdata[i], d_rdata[i],
                   (cyc == if_at), (cyc == d_at), if_hold, d_hold);
      end
      if (gi || gd) last_d = gd;
      if (gi) begin
        free_at = cyc + lat + 1; if_at = free_at; if_pend = ia ^ K; ir = 0;
      end
      if (gd) begin
        if (!dwe) begin
          free_at = cyc + lat + 1; d_at = free_at; d_pend = da ^ K;
        end
        dr = 0;
      end
    end
    tick();
    drive(i, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) drive(i, 0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_fetch_read();
    test_d_priority();
    test_store();
    test_round_robin();
    test_long_latency();
    test_reset_mid_wait();
    for (int i = 0; i < 3; i++) test_random(i, 600);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
